// File: rtl/guia_06_pkg.sv
// rtl/guia_06_pkg.sv - shared types, sizes and popcount helper for the Guia_06 minterm scanner
package guia_06_pkg;

    localparam int MINTERMS = 16;
    localparam int MASK_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    function automatic logic [4:0] popcount16(input logic [MASK_W-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MASK_W; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/guia_06_popcount16.sv
// rtl/guia_06_popcount16.sv - combinational 16-bit population count
module guia_06_popcount16
    import guia_06_pkg::*;
(
    input  logic [MASK_W-1:0] i_data,
    output logic [4:0]        o_count
);

    assign o_count = popcount16(i_data);

endmodule

// File: rtl/guia_06_minterm_scanner.sv
// rtl/guia_06_minterm_scanner.sv - walks x,y,w,z through all minterms and emits one truth-table mask per function
module guia_06_minterm_scanner
    import guia_06_pkg::*;
#(
    parameter int N_FUNC = 5,
    parameter int SETTLE = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_x,
    output logic              o_y,
    output logic              o_w,
    output logic              o_z,
    input  logic [N_FUNC-1:0] i_f_in,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [2:0]        o_res_idx,
    output logic [MASK_W-1:0] o_res_mask,
    output logic [4:0]        o_res_count,
    output logic              o_done
);

    localparam logic [3:0] LAST_MINTERM = 4'(MINTERMS - 1);
    localparam logic [2:0] LAST_IDX     = 3'(N_FUNC - 1);
    localparam logic [2:0] SETTLE_MAX   = 3'(SETTLE);

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_minterm;
    logic [2:0]        r_settle;
    logic [2:0]        r_idx;
    logic [MASK_W-1:0] r_mask [N_FUNC];
    logic              r_done;

    logic              w_sample;
    logic              w_last;
    logic              w_accept;
    logic              w_final;
    logic [MASK_W-1:0] w_sel_mask;

    assign w_sample = (r_state == SCAN) && (r_settle == SETTLE_MAX);
    assign w_last   = w_sample && (r_minterm == LAST_MINTERM);
    assign w_accept = (r_state == EMIT) && i_res_ready;
    assign w_final  = w_accept && (r_idx == LAST_IDX);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = SCAN;
            SCAN:    if (w_last)  w_state_next = EMIT;
            EMIT:    if (w_final) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // The minterm counter doubles as the x,y,w,z drive: it rests at 15 through EMIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_minterm <= '0;
            r_settle  <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            for (int k = 0; k < N_FUNC; k++) begin
                r_mask[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_minterm <= '0;
                        r_settle  <= '0;
                        r_idx     <= '0;
                        for (int k = 0; k < N_FUNC; k++) begin
                            r_mask[k] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (!w_sample) begin
                        r_settle <= r_settle + 3'd1;
                    end else begin
                        for (int k = 0; k < N_FUNC; k++) begin
                            r_mask[k][r_minterm] <= i_f_in[k];
                        end
                        r_settle <= '0;
                        r_idx    <= '0;
                        if (!w_last) begin
                            r_minterm <= r_minterm + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (w_final) begin
                        r_done    <= 1'b1;
                        r_minterm <= '0;
                        r_idx     <= '0;
                    end else if (w_accept) begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_sel_mask = '0;
        for (int k = 0; k < N_FUNC; k++) begin
            if ((r_state == EMIT) && (r_idx == 3'(k))) begin
                w_sel_mask = r_mask[k];
            end
        end
    end

    guia_06_popcount16 u_popcount (
        .i_data  (w_sel_mask),
        .o_count (o_res_count)
    );

    assign o_x         = r_minterm[3];
    assign o_y         = r_minterm[2];
    assign o_w         = r_minterm[1];
    assign o_z         = r_minterm[0];
    assign o_busy      = (r_state != IDLE);
    assign o_res_valid = (r_state == EMIT);
    assign o_res_idx   = r_idx;
    assign o_res_mask  = w_sel_mask;
    assign o_done      = r_done;

endmodule
